// File: rtl/seq_div8x4_pkg.sv
// Shared types for the seq_div8x4 restoring divider.
// FSM state encoding and default operand widths.
package seq_div_pkg;

    localparam int DIV_DW = 8;
    localparam int DIV_VW = 4;
    localparam int DIV_CW = $clog2(DIV_DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_div8x4_if.sv
// Operand/result valid-ready bundle for seq_div8x4.
// master = requester/consumer side, slave = divider side.
interface seq_div8x4_if
    import seq_div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
);

    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_by_zero;
    logic          chk_err;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder,
        input  div_by_zero, chk_err
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder,
        output div_by_zero, chk_err
    );

endinterface

// File: rtl/seq_div8x4_div_step.sv
// One restoring division step: shift in a dividend bit,
// subtract the divisor if it fits, emit the quotient bit.
module div_step #(
    parameter int VW = 4
) (
    input  logic [VW:0]   i_pr,
    input  logic          i_bit,
    input  logic [VW-1:0] i_divisor,
    output logic [VW:0]   o_pr,
    output logic          o_q
);

    logic [VW+1:0] w_t;
    logic [VW+1:0] w_d;
    logic [VW:0]   w_diff;

    assign w_t    = {i_pr, i_bit};
    assign w_d    = {2'b00, i_divisor};
    assign o_q    = (w_t >= w_d);
    assign w_diff = w_t[VW:0] - w_d[VW:0];
    assign o_pr   = o_q ? w_diff : w_t[VW:0];

endmodule

// File: rtl/seq_div8x4.sv
// Sequential radix-2 restoring divider, one quotient bit per cycle.
// SEQ_DIV_SELFCHECK_EN adds a q*d+r==dividend check (one extra cycle).
module seq_div8x4
    import seq_div_pkg::*;
#(
    parameter int DW = DIV_DW,
    parameter int VW = DIV_VW
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_div8x4_if.slave  bus
);

    localparam int CW = $clog2(DW);

    div_state_t    r_state;
    logic [DW-1:0] r_dvd;
    logic [VW-1:0] r_dvs;
    logic [VW:0]   r_pr;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_quotient;
    logic [VW-1:0] r_remainder;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_dbz;

    logic [VW:0]   w_pr_nxt;
    logic          w_qbit;

`ifdef SEQ_DIV_SELFCHECK_EN
    logic [DW-1:0]    r_orig;
    logic             r_chk_ph;
    logic             r_chk;
    logic [DW+VW-1:0] w_prod;

    assign w_prod = (DW+VW)'(r_quotient) * (DW+VW)'(r_dvs)
                  + (DW+VW)'(r_remainder);
    assign bus.chk_err = r_chk;
`else
    assign bus.chk_err = 1'b0;
`endif

    div_step #(.VW(VW)) u_step (
        .i_pr      (r_pr),
        .i_bit     (r_dvd[DW-1]),
        .i_divisor (r_dvs),
        .o_pr      (w_pr_nxt),
        .o_q       (w_qbit)
    );

    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.quotient    = r_quotient;
    assign bus.remainder   = r_remainder;
    assign bus.div_by_zero = r_dbz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_dvd       <= '0;
            r_dvs       <= '0;
            r_pr        <= '0;
            r_cnt       <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_dbz       <= 1'b0;
`ifdef SEQ_DIV_SELFCHECK_EN
            r_orig      <= '0;
            r_chk_ph    <= 1'b0;
            r_chk       <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_dvd      <= bus.dividend;
                        r_dvs      <= bus.divisor;
                        r_pr       <= '0;
                        r_cnt      <= CW'(DW-1);
                        r_quotient <= '0;
                        r_in_ready <= 1'b0;
`ifdef SEQ_DIV_SELFCHECK_EN
                        r_orig     <= bus.dividend;
                        r_chk      <= 1'b0;
`endif
                        if (bus.divisor == '0) begin
                            // Divide-by-zero skips RUN and the self-check.
                            r_state     <= DONE;
                            r_quotient  <= '1;
                            r_remainder <= bus.dividend[VW-1:0];
                            r_dbz       <= 1'b1;
                            r_out_valid <= 1'b1;
`ifdef SEQ_DIV_SELFCHECK_EN
                            r_chk_ph    <= 1'b1;
`endif
                        end else begin
                            r_state     <= RUN;
                            r_dbz       <= 1'b0;
`ifdef SEQ_DIV_SELFCHECK_EN
                            r_chk_ph    <= 1'b0;
`endif
                        end
                    end
                end
                RUN: begin
                    r_dvd      <= {r_dvd[DW-2:0], 1'b0};
                    r_pr       <= w_pr_nxt;
                    r_quotient <= {r_quotient[DW-2:0], w_qbit};
                    if (r_cnt == '0) begin
                        r_state     <= DONE;
                        r_remainder <= w_pr_nxt[VW-1:0];
`ifndef SEQ_DIV_SELFCHECK_EN
                        r_out_valid <= 1'b1;
`endif
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                DONE: begin
`ifdef SEQ_DIV_SELFCHECK_EN
                    if (!r_chk_ph) begin
                        r_chk_ph    <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_chk       <= (w_prod != {{VW{1'b0}}, r_orig});
                    end else if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_chk       <= 1'b0;
                    end
`else
                    if (bus.out_ready) begin
                        r_state     <= IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
`endif
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div8x4.sv
// Randomized scoreboard bench for seq_div8x4 against
// an arithmetic reference model.
module tb_seq_div8x4;
    import seq_div_pkg::*;

`ifdef SEQ_DIV_SELFCHECK_EN
    localparam int LAT = 10;
`else
    localparam int LAT = 9;
`endif

    typedef struct {
        logic [7:0] a;
        logic [3:0] b;
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
        int         acc;
        int         lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    seq_div8x4_if #(.DW(8), .VW(4)) bus();

    seq_div8x4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    exp_t sb[$];
    bit   bp_rand  = 1'b0;
    bit   hold_low = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a,
                                   input logic [3:0] b,
                                   input int acc);
        exp_t m;
        m.a = a;
        m.b = b;
        m.acc = acc;
        if (b == 4'd0) begin
            m.q = 8'hFF;
            m.r = 4'(a % 16);
            m.z = 1'b1;
            m.lat = 1;
        end else begin
            m.q = 8'(int'(a) / int'(b));
            m.r = 4'(int'(a) % int'(b));
            m.z = 1'b0;
            m.lat = LAT;
        end
        return m;
    endfunction

    always @(posedge clk) begin
        #1;
        if (hold_low) bus.out_ready = 1'b0;
        else if (bp_rand) bus.out_ready = ($urandom_range(0, 2) != 0);
        else bus.out_ready = 1'b1;
    end

    // Monitor: pops the scoreboard on first sight of each result
    bit         seen = 1'b0;
    bit         popped = 1'b0;
    exp_t       cur;
    logic [7:0] hq;
    logic [3:0] hr;
    logic       hz;

    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
            popped = 1'b0;
        end else begin
            if (popped) begin
                check("idle_after_hs", {bus.out_valid, bus.in_ready}, 1);
                popped = 1'b0;
            end
            if (bus.out_valid) begin
                if (!seen) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out_valid", 1, 0);
                    end else begin
                        cur = sb.pop_front();
                        check("latency", cyc - cur.acc + 1, cur.lat);
                        check("quotient", bus.quotient, cur.q);
                        check("remainder", bus.remainder, cur.r);
                        check("div_by_zero", bus.div_by_zero, cur.z);
                    end
                    seen = 1'b1;
                    hq = bus.quotient;
                    hr = bus.remainder;
                    hz = bus.div_by_zero;
                end else begin
                    check("stable", {bus.quotient, bus.remainder,
                                     bus.div_by_zero},
                          {hq, hr, hz});
                end
                check("chk_err", bus.chk_err, 0);
                check("in_ready_in_done", bus.in_ready, 0);
                if (bus.out_ready) begin
                    seen = 1'b0;
                    popped = 1'b1;
                end
            end
        end
    end

    task automatic issue(input logic [7:0] a, input logic [3:0] b,
                         input bit track);
        int w;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor = b;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("accept", bus.in_ready, 1);
        if (bus.in_ready && track) sb.push_back(model(a, b, cyc + 1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        int w;
        int hits;
        bus.in_valid = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        #12;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_quotient", bus.quotient, 0);
        check("rst_remainder", bus.remainder, 0);
        check("rst_dbz", bus.div_by_zero, 0);
        check("rst_chk_err", bus.chk_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", bus.in_ready, 1);

        issue(8'd200, 4'd7, 1'b1);
        issue(8'd255, 4'd15, 1'b1);
        issue(8'd13, 4'd1, 1'b1);
        issue(8'd0, 4'd5, 1'b1);
        issue(8'd100, 4'd0, 1'b1);

        // Hold out_ready low for 5 cycles in DONE
        hold_low = 1'b1;
        issue(8'd200, 4'd7, 1'b1);
        w = 0;
        while (!bus.out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("bp_done_reached", bus.out_valid, 1);
        repeat (5) @(negedge clk);
        hold_low = 1'b0;
        repeat (4) @(negedge clk);

        // Abort mid-RUN with reset
        issue(8'd200, 4'd7, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_quotient", bus.quotient, 0);
        check("abort_remainder", bus.remainder, 0);
        check("abort_dbz", bus.div_by_zero, 0);
        check("abort_chk_err", bus.chk_err, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("abort_in_ready", bus.in_ready, 1);
        hits = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) hits++;
        end
        check("abort_no_out_valid", hits, 0);
        issue(8'd50, 4'd6, 1'b1);

        bp_rand = 1'b1;
        for (int b = 0; b < 16; b++) begin
            issue(8'(b * 17), 4'(b), 1'b1);
            issue(8'hFF, 4'(b), 1'b1);
        end
        for (int i = 0; i < 400; i++) begin
            issue(8'($urandom_range(0, 255)),
                  4'($urandom_range(0, 15)), 1'b1);
        end
        bp_rand = 1'b0;

        w = 0;
        while ((sb.size() != 0 || bus.out_valid) && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("drain", sb.size(), 0);
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
